hazard_forwarding_unit: RTL and testbench
=========================================

# hazard_forwarding_unit

Pipeline hazard and forwarding controller for the 5-stage MIPS core. It sits directly upstream of the ID-stage control NOP mux and the two register-file port forwarding muxes, and generates their select lines. It keeps its own shadow copy of in-flight destination registers for EX, MEM and WB. From that copy it derives 2-bit operand forwarding selects, a one-cycle load-use stall (NOP insertion plus PC/NPC/IF-ID hold), and a saturating stall counter.

## Interface
Parameters:
- CNT_W, 16, width of stall_count

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  instruction in ID reads rs
- id_uses_rt  in  1  instruction in ID reads rt
- id_dest  in  5  destination register of ID instruction (after RD/RT/R31 selection)
- id_rf_enable  in  1  ID instruction writes the register file
- id_load_instr  in  1  ID instruction is a load
- fwd_sel_a  out  2  select for port A mux: 00 RF/ID, 01 EX, 10 MEM, 11 WB
- fwd_sel_b  out  2  same encoding, port B
- control_mux  out  1  1 = drive zeroed control word into ID/EX (NOP)
- pc_le  out  1  PC load enable
- npc_le  out  1  NPC load enable
- if_id_le  out  1  IF/ID register load enable
- stall_count  out  CNT_W  number of load-use stall cycles since reset, saturating

## Operation
- Shadow pipeline: three entries ex, mem, wb, each holding {dest[4:0], rf_en, load}.
- Every rising clk edge: wb <= mem; mem <= ex; ex <= stall ? bubble : {id_dest, id_rf_enable, id_load_instr}. A bubble is dest=0, rf_en=0, load=0.
- Match on stage X for operand r: X.rf_en && X.dest != 0 && X.dest == r && uses_r.
- Forwarding priority is EX > MEM > WB. Register 0 is never forwarded. With no match the select is 00.
- Load-use stall is asserted when ex.load && (match(ex, rs) || match(ex, rt)).
- While stall is asserted: control_mux=1, pc_le=0, npc_le=0, if_id_le=0.
- While stall is deasserted: control_mux=0, pc_le=1, npc_le=1, if_id_le=1.
- The stall lasts exactly one cycle. On the next cycle the load sits in MEM, the held ID instruction re-evaluates, and it gets select 10.
- stall_count increments by 1 on each clk edge where stall=1. It holds at all-ones; no wrap.
- Forwarding selects are still computed during a stall cycle; downstream ignores them because control_mux=1.

## Timing
- Selects, stall and enables are combinational from the registered shadow state plus the current id_* inputs, with zero-cycle latency. Shadow state and counter update on posedge clk only.
- Reset: on a clk edge with reset=1, all shadow entries become bubbles and stall_count=0. While reset is high the outputs are forced to: fwd_sel_a=00, fwd_sel_b=00, control_mux=0, pc_le=1, npc_le=1, if_id_le=1.
- Reset asserted during a stall cycle: the stall is abandoned, and the first cycle after reset shows no stall.
- rs == rt, both used and both matching: fwd_sel_a and fwd_sel_b carry the same value.
- If id_uses_r=0, that operand's select is 00 regardless of any match.
- A load in EX targeting r0 never stalls.

## Structure
- Shared package mips_pkg holds:
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11
  - packed struct shadow_entry_t {dest, rf_en, load}
  - BUBBLE constant
- One sub-module, fwd_select. It takes one operand (reg, uses) plus the three shadow entries and returns the 2-bit select and an ex_load_hit flag. It is instantiated twice, for rs and rt.
- The top level holds the shadow registers, the stall OR and the counter.

## Test plan
- Reset check: assert reset 2 cycles, then deassert. Required: fwd selects 00, control_mux=0, all LEs=1, stall_count=0.
- ALU to ALU chain: "add r3" enters ID, then "add r4,r3,r1" follows (uses_rs, rs=3). Required: fwd_sel_a=01. With one independent instruction between them: 10. With two between: 11. With three between: 00.
- Load-use on rt: "lw r5" followed by "sub r6,r2,r5" (rt=5). Required in cycle 1: control_mux=1, pc_le=npc_le=if_id_le=0, stall_count becomes 1. Required in cycle 2: control_mux=0, fwd_sel_b=10.
- r0 and priority: an instruction writing r0 is followed by one reading r0. Required: select 00, no stall. Separately, EX and MEM both write r7 and ID reads r7 on both ports. Required: fwd_sel_a=fwd_sel_b=01.
- Reset mid-stall: create a load-use stall, then assert reset on that cycle. Required next cycle: stall deasserted, shadow cleared (a following reader of r5 gets 00), stall_count=0.
- Saturation: with CNT_W=2, produce 5 load-use stalls. Required: stall_count=3 and it holds at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding select
// encodings and the shadow-pipeline entry used to track in-flight writers.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [4:0] dest;
    logic       rf_en;
    logic       load;
  } shadow_entry_t;

  localparam shadow_entry_t BUBBLE = '{dest: 5'd0, rf_en: 1'b0, load: 1'b0};

  // An in-flight writer produces a value this operand needs; r0 never counts.
  function automatic logic entry_hit(shadow_entry_t e, logic [4:0] r, logic uses);
    return e.rf_en && (e.dest != 5'd0) && (e.dest == r) && uses;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight writer of the
// operand and flags when that writer is a load still sitting in EX.
module fwd_select
  import mips_pkg::*;
(
  input  logic [4:0]    i_reg,
  input  logic          i_uses,
  input  shadow_entry_t i_ex,
  input  shadow_entry_t i_mem,
  input  shadow_entry_t i_wb,
  output logic [1:0]    o_sel,
  output logic          o_ex_load_hit
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_ex  = entry_hit(i_ex,  i_reg, i_uses);
  assign w_hit_mem = entry_hit(i_mem, i_reg, i_uses);
  assign w_hit_wb  = entry_hit(i_wb,  i_reg, i_uses);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex)       o_sel = FWD_EX;
    else if (w_hit_mem) o_sel = FWD_MEM;
    else if (w_hit_wb)  o_sel = FWD_WB;
  end

  assign o_ex_load_hit = w_hit_ex && i_ex.load;

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Hazard/forwarding controller: shadow copy of EX/MEM/WB destinations, operand
// forwarding selects, one-cycle load-use stall and a saturating stall counter.
module hazard_forwarding_unit
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_rf_enable,
  input  logic             id_load_instr,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             control_mux,
  output logic             pc_le,
  output logic             npc_le,
  output logic             if_id_le,
  output logic [CNT_W-1:0] stall_count
);

  shadow_entry_t    r_ex;
  shadow_entry_t    r_mem;
  shadow_entry_t    r_wb;
  logic [CNT_W-1:0] r_stall_count;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_load_hit_a;
  logic       w_load_hit_b;
  logic       w_stall;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  fwd_select u_fwd_a (
    .i_reg         (id_rs),
    .i_uses        (id_uses_rs),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .i_wb          (r_wb),
    .o_sel         (w_sel_a),
    .o_ex_load_hit (w_load_hit_a)
  );

  fwd_select u_fwd_b (
    .i_reg         (id_rt),
    .i_uses        (id_uses_rt),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .i_wb          (r_wb),
    .o_sel         (w_sel_b),
    .o_ex_load_hit (w_load_hit_b)
  );

  // Reset overrides everything so an in-progress stall is abandoned.
  assign w_stall     = !reset && (w_load_hit_a || w_load_hit_b);
  assign fwd_sel_a   = reset ? FWD_RF : w_sel_a;
  assign fwd_sel_b   = reset ? FWD_RF : w_sel_b;
  assign control_mux = w_stall;
  assign pc_le       = !w_stall;
  assign npc_le      = !w_stall;
  assign if_id_le    = !w_stall;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex          <= BUBBLE;
      r_mem         <= BUBBLE;
      r_wb          <= BUBBLE;
      r_stall_count <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_stall ? BUBBLE
                       : '{dest: id_dest, rf_en: id_rf_enable, load: id_load_instr};
      if (w_stall) r_stall_count <= sat_inc(r_stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed bench for hazard_forwarding_unit; a second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_hazard_forwarding_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_rf_enable, id_load_instr;

  logic [1:0]  fwd_sel_a, fwd_sel_b, fwd_sel_a2, fwd_sel_b2;
  logic        control_mux, pc_le, npc_le, if_id_le;
  logic        control_mux2, pc_le2, npc_le2, if_id_le2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_forwarding_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .control_mux(control_mux),
    .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le), .stall_count(stall_count)
  );

  hazard_forwarding_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
    .fwd_sel_a(fwd_sel_a2), .fwd_sel_b(fwd_sel_b2), .control_mux(control_mux2),
    .pc_le(pc_le2), .npc_le(npc_le2), .if_id_le(if_id_le2), .stall_count(stall_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag);
    check({tag, "_cm"}, {31'd0, control_mux}, 32'd0);
    check({tag, "_le"}, {29'd0, pc_le, npc_le, if_id_le}, 32'h7);
  endtask

  task automatic chk_stall(input string tag);
    check({tag, "_cm"}, {31'd0, control_mux}, 32'd1);
    check({tag, "_le"}, {29'd0, pc_le, npc_le, if_id_le}, 32'h0);
  endtask

  // Present one ID instruction for the current cycle.
  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] dest, input logic rfen,
                        input logic ld);
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_dest = dest; id_rf_enable = rfen; id_load_instr = ld;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic flush();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) adv();
  endtask

  initial begin
    reset = 1'b1;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    adv();
    adv();
    // Reset held: a would-be match must still be forced to 00.
    set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    sample();
    check("rst_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    chk_run("rst");
    #1 reset = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    adv();
    sample();
    check("rst_sel_b", {30'd0, fwd_sel_b}, 32'd0);
    check("rst_cnt", {16'd0, stall_count}, 32'd0);
    chk_run("post_rst");
    adv();

    // ALU chains at distance 1..4
    for (int gap = 0; gap < 4; gap++) begin
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      adv();
      for (int k = 0; k < gap; k++) begin
        set_id(5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
        adv();
      end
      set_id(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
      sample();
      case (gap)
        0: check("chain_gap0", {30'd0, fwd_sel_a}, 32'd1);
        1: check("chain_gap1", {30'd0, fwd_sel_a}, 32'd2);
        2: check("chain_gap2", {30'd0, fwd_sel_a}, 32'd3);
        default: check("chain_gap3", {30'd0, fwd_sel_a}, 32'd0);
      endcase
      check("chain_b", {30'd0, fwd_sel_b}, 32'd0);
      adv();
      flush();
    end

    // Load-use on rt
    set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    adv();
    set_id(5'd2, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    sample();
    chk_stall("lu_c1");
    check("lu_c1_selb", {30'd0, fwd_sel_b}, 32'd1);
    adv();
    sample();
    chk_run("lu_c2");
    check("lu_c2_selb", {30'd0, fwd_sel_b}, 32'd2);
    check("lu_c2_sela", {30'd0, fwd_sel_a}, 32'd0);
    check("lu_cnt", {16'd0, stall_count}, 32'd1);
    adv();
    flush();

    // Writer of r0, then reader of r0
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    adv();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    sample();
    check("r0_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    chk_run("r0");
    adv();
    flush();
    // Load to r0 never stalls
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    adv();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    sample();
    chk_run("r0_load");
    adv();
    flush();

    // EX and MEM both write r7: EX wins on both ports
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    adv();
    adv();
    set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0);
    sample();
    check("prio_a", {30'd0, fwd_sel_a}, 32'd1);
    check("prio_b", {30'd0, fwd_sel_b}, 32'd1);
    // Operand not used: select stays 00 despite match
    set_id(5'd7, 1'b0, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    check("nouse_a", {30'd0, fwd_sel_a}, 32'd0);
    check("nouse_b", {30'd0, fwd_sel_b}, 32'd1);
    adv();
    flush();

    // Reset asserted during a load-use stall
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    adv();
    set_id(5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    sample();
    chk_stall("mid_pre");
    #1 reset = 1'b1;
    #1 chk_run("mid_in_rst");
    adv();
    reset = 1'b0;
    sample();
    chk_run("mid_post");
    check("mid_selb", {30'd0, fwd_sel_b}, 32'd0);
    check("mid_cnt", {16'd0, stall_count}, 32'd0);
    check("mid_cnt2", {30'd0, stall_count2}, 32'd0);
    adv();
    flush();

    // Five load-use stalls: 2-bit counter saturates at 3
    for (int n = 1; n <= 5; n++) begin
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      adv();
      set_id(5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      adv();
      sample();
      check("sat_step", {30'd0, stall_count2}, (n > 3) ? 32'd3 : n);
      adv();
    end
    check("sat_wide", {16'd0, stall_count}, 32'd5);
    flush();
    sample();
    check("sat_hold", {30'd0, stall_count2}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
